// File: rtl/kernel_launcher_pkg.sv
// Shared definitions for the kernel launcher: FSM state encoding and the
// counter saturation helper.
package kernel_launcher_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  // All-ones value for a counter of the given width (up to 64 bits).
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/launcher_result_slot.sv
// One-entry valid/ready output register; a new capture takes priority over
// draining the current entry.
module launcher_result_slot #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/kernel_launcher.sv
// Host-side ap_start/ap_ready/ap_done initiator: launches one kernel run per
// argument token and returns the result with its RUN-cycle latency.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int ARG_WIDTH = 8,
  parameter int RES_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARG_WIDTH-1:0] arg_in,
  input  logic                 arg_valid,
  output logic                 arg_ready,
  output logic [RES_WIDTH-1:0] res_out,
  output logic [CNT_WIDTH-1:0] res_cycles,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic [ARG_WIDTH-1:0] k_arg,
  input  logic [RES_WIDTH-1:0] k_res,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(sat_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] WDT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic [1:0]                     state, state_next;
  logic [CNT_WIDTH-1:0]           cnt, cnt_inc;
  logic                           accept, capture, wdt_hit;
  logic [RES_WIDTH+CNT_WIDTH-1:0] slot_data;

  // The kernel cannot stall ap_done, so a token is only taken once the
  // result slot is guaranteed free.
  assign arg_ready = !rst && (state == ST_IDLE) && (!res_valid || res_ready);
  assign accept    = arg_valid && arg_ready;
  assign ap_start  = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE);
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
  assign capture   = (state == ST_RUN) && ap_done;
  assign wdt_hit   = (TIMEOUT != 0) && (state == ST_RUN) && !ap_done && (cnt == WDT_LAST);

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_LAUNCH;
      ST_LAUNCH: if (ap_ready) state_next = ST_RUN;
      ST_RUN: begin
        if (capture)      state_next = ST_IDLE;
        else if (wdt_hit) state_next = ST_ERROR;
      end
      default:   state_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k_arg   <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) k_arg <= arg_in;
      if (state == ST_LAUNCH && ap_ready) cnt <= '0;
      else if (state == ST_RUN)           cnt <= cnt_inc;
      if (wdt_hit) timeout <= 1'b1;
    end
  end

  launcher_result_slot #(
    .WIDTH(RES_WIDTH + CNT_WIDTH)
  ) u_slot (
    .clk    (clk),
    .rst    (rst),
    .capture(capture),
    .data_in({k_res, cnt_inc}),
    .ready  (res_ready),
    .valid  (res_valid),
    .data   (slot_data)
  );

  assign res_out    = slot_data[RES_WIDTH+CNT_WIDTH-1:CNT_WIDTH];
  assign res_cycles = slot_data[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: mock factorial kernel, transaction-level model
// checked every cycle, directed vectors and randomized traffic.
module tb_kernel_launcher;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  arg_in;
  logic        arg_valid, arg_ready;
  logic [7:0]  res_out;
  logic [15:0] res_cycles;
  logic        res_valid, res_ready;
  logic        ap_start, ap_ready, ap_done;
  logic [7:0]  k_arg, k_res;
  logic        busy, timeout;

  logic        s_capture, s_ready, s_valid;
  logic [7:0]  s_data_in, s_data;

  always #5 clk = ~clk;

  kernel_launcher #(
    .ARG_WIDTH(8), .RES_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .arg_in(arg_in), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .res_out(res_out), .res_cycles(res_cycles), .res_valid(res_valid), .res_ready(res_ready),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .k_arg(k_arg), .k_res(k_res), .busy(busy), .timeout(timeout)
  );

  launcher_result_slot #(.WIDTH(8)) u_slot (
    .clk(clk), .rst(rst), .capture(s_capture), .data_in(s_data_in),
    .ready(s_ready), .valid(s_valid), .data(s_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fact(input logic [7:0] n);
    logic [7:0] p;
    p = 8'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 8'(i);
    return p;
  endfunction

  // Transaction-level model and mock kernel state
  typedef struct { logic [7:0] res; int cyc; } res_t;
  res_t       q[$];
  bit         launching, running, err;
  int         run_n, stall_left, k_cnt, cfg_lat, cfg_stall;
  logic [7:0] cur_arg, kern_arg;
  bit         last_acc, last_hs;

  // One clock cycle: check DUT against the model, then advance both.
  task automatic tick();
    bit   e_ar, acc, hs, done, wd, drain;
    res_t r;
    #1;
    e_ar = !rst && !launching && !running && !err && (q.size() == 0 || res_ready);
    check("arg_ready", arg_ready, e_ar);
    check("ap_start", ap_start, launching);
    check("busy", busy, launching || running || err);
    check("timeout", timeout, err);
    check("res_valid", res_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("res_out", res_out, q[0].res);
      check("res_cycles", res_cycles, q[0].cyc);
    end
    if (launching || running) check("k_arg", k_arg, cur_arg);
    acc   = e_ar && arg_valid;
    hs    = launching && ap_ready;
    done  = running && ap_done;
    wd    = running && !done && (run_n + 1 == TO);
    drain = (q.size() != 0) && res_ready;
    if (hs) kern_arg = k_arg;
    @(posedge clk);
    #1;
    last_acc = acc && !rst;
    last_hs  = hs && !rst;
    if (rst) begin
      q.delete();
      launching = 0; running = 0; err = 0;
      run_n = 0; stall_left = 0; k_cnt = 0;
    end else begin
      if (drain) void'(q.pop_front());
      if (done) begin
        r.res = fact(cur_arg);
        r.cyc = run_n + 1;
        q.push_back(r);
      end
      if (running) run_n++;
      if (done || wd) running = 0;
      if (wd) err = 1;
      if (k_cnt > 0) k_cnt--;
      if (hs) begin
        launching = 0; running = 1; run_n = 0; k_cnt = cfg_lat;
      end else if (launching && stall_left > 0) begin
        stall_left--;
      end
      if (acc) begin
        launching = 1; cur_arg = arg_in; stall_left = cfg_stall;
      end
    end
    ap_ready = (stall_left == 0);
    ap_done  = (k_cnt == 1);
    k_res    = ap_done ? fact(kern_arg) : 8'($urandom);
  endtask

  task automatic launch(input logic [7:0] a, input int lat, input int stall);
    bit got;
    got = 0;
    cfg_lat = lat; cfg_stall = stall; arg_in = a; arg_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) begin got = 1; break; end
    end
    check("launch_accept", got, 1);
    arg_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) begin got = 1; break; end
    end
    check(name, got, 1);
  endtask

  typedef struct {
    logic [7:0] arg; int lat; int stall; logic [7:0] res; int cyc; int starts;
  } vec_t;
  vec_t vec[6];

  initial begin
    int n_start, n;
    bit got;

    vec[0] = '{arg: 8'd5, lat: 3,  stall: 0, res: 8'd120, cyc: 3,  starts: 1};
    vec[1] = '{arg: 8'd3, lat: 1,  stall: 0, res: 8'd6,   cyc: 1,  starts: 1};
    vec[2] = '{arg: 8'd4, lat: 2,  stall: 4, res: 8'd24,  cyc: 2,  starts: 5};
    vec[3] = '{arg: 8'd2, lat: 10, stall: 1, res: 8'd2,   cyc: 10, starts: 2};
    vec[4] = '{arg: 8'd6, lat: 7,  stall: 2, res: 8'd208, cyc: 7,  starts: 3};
    vec[5] = '{arg: 8'd0, lat: 4,  stall: 0, res: 8'd1,   cyc: 4,  starts: 1};

    rst = 1'b1; arg_valid = 1'b0; arg_in = '0; res_ready = 1'b1;
    ap_ready = 1'b1; ap_done = 1'b0; k_res = '0;
    s_capture = 1'b0; s_data_in = '0; s_ready = 1'b0;
    cfg_lat = 3; cfg_stall = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_arg_ready", arg_ready, 0);
    check("rst_ap_start", ap_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_out", res_out, 0);
    check("rst_res_cycles", res_cycles, 0);
    check("rst_k_arg", k_arg, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Table of single launches, including ap_done on the watchdog limit
    foreach (vec[v]) begin
      res_ready = 1'b1;
      launch(vec[v].arg, vec[v].lat, vec[v].stall);
      n_start = ap_start ? 1 : 0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (res_valid) begin got = 1; break; end
        if (ap_start) n_start++;
      end
      check("vec_done", got, 1);
      check("vec_res", res_out, vec[v].res);
      check("vec_cycles", res_cycles, vec[v].cyc);
      check("vec_starts", n_start, vec[v].starts);
      check("vec_busy_after", busy, 0);
      check("vec_no_timeout", timeout, 0);
      tick();
    end

    // Output backpressure
    res_ready = 1'b0;
    launch(8'd3, 2, 0);
    wait_result("bp_first_done");
    check("bp_first_res", res_out, 6);
    arg_in = 8'd4; arg_valid = 1'b1; cfg_lat = 3; cfg_stall = 0;
    repeat (3) begin
      tick();
      check("bp_no_start", ap_start, 0);
      check("bp_arg_blocked", arg_ready, 0);
      check("bp_hold_res", res_out, 6);
    end
    res_ready = 1'b1;
    #1;
    check("bp_ready_same_cycle", arg_ready, 1);
    tick();
    check("bp_second_accept", last_acc, 1);
    arg_valid = 1'b0;
    wait_result("bp_second_done");
    check("bp_second_res", res_out, 24);
    check("bp_second_cycles", res_cycles, 3);
    tick();

    // Watchdog: kernel answers only after the limit
    launch(8'd7, 15, 0);
    tick();
    check("wd_handshake", last_hs, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (timeout) break;
    end
    check("wd_run_cycles", n, TO);
    arg_valid = 1'b1; arg_in = 8'd1;
    repeat (10) begin
      tick();
      check("wd_arg_ready", arg_ready, 0);
      check("wd_no_result", res_valid, 0);
      check("wd_sticky", timeout, 1);
    end
    arg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("wd_cleared", timeout, 0);
    check("wd_arg_ready_back", arg_ready, 1);

    // Reset two cycles into RUN
    launch(8'd9, 8, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_res_valid", res_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_ap_start", ap_start, 0);
    check("mid_k_arg", k_arg, 0);
    check("mid_timeout", timeout, 0);
    check("mid_res_out", res_out, 0);
    check("mid_res_cycles", res_cycles, 0);
    rst = 1'b0;
    launch(8'd5, 3, 0);
    wait_result("mid_relaunch_done");
    check("mid_relaunch_res", res_out, 120);
    check("mid_relaunch_cycles", res_cycles, 3);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      arg_valid = 1'($urandom_range(0, 1));
      arg_in    = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cfg_lat   = $urandom_range(1, 10);
      cfg_stall = $urandom_range(0, 3);
      tick();
    end
    arg_valid = 1'b0; res_ready = 1'b1;
    repeat (25) tick();
    check("rand_drained", res_valid, 0);

    // Result slot: capture coincident with drain keeps the new entry
    s_capture = 1'b1; s_data_in = 8'h11; s_ready = 1'b0;
    @(posedge clk); #1;
    check("slot_capture_valid", s_valid, 1);
    check("slot_capture_data", s_data, 8'h11);
    s_data_in = 8'h22; s_ready = 1'b1;
    @(posedge clk); #1;
    check("slot_race_valid", s_valid, 1);
    check("slot_race_data", s_data, 8'h22);
    s_capture = 1'b0; s_ready = 1'b0; s_data_in = 8'h33;
    @(posedge clk); #1;
    check("slot_hold_valid", s_valid, 1);
    check("slot_hold_data", s_data, 8'h22);
    s_ready = 1'b1;
    @(posedge clk); #1;
    check("slot_drain_valid", s_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_launcher.md
Name: kernel_launcher

Overview:
Host-side initiator for the ap_start/ap_ready/ap_done kernel control protocol used by the generated top-level kernel wrappers.
- Consumes argument tokens from a valid/ready stream and launches one kernel invocation per token.
- Holds the argument stable for the kernel and captures the kernel result on ap_done.
- Returns the result, plus the measured run latency, on a valid/ready output stream.
- Used in test harnesses and multi-invocation benchmark drivers; one launcher drives one kernel instance.

Parameters:
ARG_WIDTH, 8, width of the kernel argument.
RES_WIDTH, 8, width of the kernel result.
CNT_WIDTH, 16, width of the run-latency counter.
TIMEOUT, 0, watchdog limit in cycles spent in RUN; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; also resets the attached kernel
arg_in  in  ARG_WIDTH  argument token
arg_valid  in  1  argument token valid
arg_ready  out  1  launcher accepts a token
res_out  out  RES_WIDTH  captured kernel result
res_cycles  out  CNT_WIDTH  RUN-state cycle count of the invocation that produced res_out
res_valid  out  1  result slot full
res_ready  in  1  consumer takes the result
ap_start  out  1  kernel start request
ap_ready  in  1  kernel idle, able to take a start
ap_done  in  1  single-cycle kernel completion pulse; k_res is valid in this cycle
k_arg  out  ARG_WIDTH  argument to kernel
k_res  in  RES_WIDTH  kernel result
busy  out  1  state is not IDLE
timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset values:
  - state IDLE; ap_start=0; arg_ready=0 during the reset cycle.
  - res_valid=0; res_out=0; res_cycles=0; k_arg=0; timeout=0; busy=0.
- FSM states: IDLE, LAUNCH, RUN, ERROR.
- IDLE:
  - arg_ready = !res_valid || res_ready. This guarantees the result slot is free before ap_done can arrive, because the kernel has no backpressure.
  - On arg_valid && arg_ready: arg_in is latched into k_arg and the FSM moves to LAUNCH.
- LAUNCH:
  - ap_start=1 and k_arg is held constant.
  - On ap_start && ap_ready: move to RUN and clear the cycle counter to 0.
  - If ap_ready stays low, ap_start stays high indefinitely. The watchdog does not run in LAUNCH.
- RUN:
  - ap_start=0; the counter increments every cycle and saturates at all-ones.
  - On ap_done: res_out<=k_res, res_cycles<=counter+1 (saturating), res_valid<=1, next state IDLE.
  - Net effect: res_cycles counts RUN cycles including the ap_done cycle. ap_done in the first RUN cycle gives 1.
- Watchdog: if TIMEOUT>0 and the counter reaches TIMEOUT-1 in RUN without ap_done, go to ERROR and set timeout=1.
- Simultaneous ap_done and timeout in the same cycle: ap_done wins. The result is captured and there is no error.
- ERROR:
  - arg_ready=0 and ap_start=0; ap_done is ignored.
  - The result slot still drains normally.
  - Only rst exits ERROR.
- ap_done outside RUN is ignored; no capture, no state change.
- Output slot:
  - res_valid clears on res_valid && res_ready, unless a new capture happens in the same cycle; capture has priority and res_valid stays 1.
  - res_out and res_cycles hold while res_valid && !res_ready.
- Latency (back-to-back, no stalls):
  - Token accepted at cycle t gives ap_start=1 at t+1 and RUN at t+2 if ap_ready was high at t+1.
  - ap_done at cycle d gives res_valid=1 at d+1 and arg_ready possibly 1 at d+1.
- Reset mid-operation: every state returns to reset values in the next cycle. Any in-flight invocation is abandoned and no result is emitted.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, LAUNCH=1, RUN=2, ERROR=3), 2 bits;
  - a saturating-increment helper constant (all-ones limit per CNT_WIDTH).
- One natural sub-module: launcher_result_slot. It is a one-entry valid/ready output register with capture-priority-over-drain. It holds res_out and res_cycles and is parameterised by RES_WIDTH+CNT_WIDTH.
- FSM, argument register and counter stay in the top.

Test Plan:
- Single launch, ARG 5:
  - Stimulus: ap_ready=1; mock kernel pulses ap_done 3 cycles after the start handshake with k_res=120; res_ready=1.
  - Required: ap_start high exactly 1 cycle, k_arg=5 throughout, res_out=120, res_cycles=3, busy low again the cycle after ap_done.
- Start stall:
  - Stimulus: hold ap_ready=0 for 4 cycles after token accept.
  - Required: ap_start stays 1 for 5 cycles with k_arg stable; RUN is entered only on the cycle ap_ready=1.
- Output backpressure:
  - Stimulus: res_ready=0 after the first result; offer a second token.
  - Required: arg_ready=0 and no second ap_start. When res_ready=1, arg_ready=1 in the same cycle, the second token is accepted, and the second result is correct (args 3 and 4 -> mock results 6 and 24).
- Watchdog:
  - Stimulus: TIMEOUT=10; kernel never pulses ap_done.
  - Required: timeout=1 after 10 RUN cycles; arg_ready=0 thereafter; ap_done arriving later is ignored. rst clears timeout and restores arg_ready=1.
- Boundary races:
  - ap_done coincident with the timeout limit -> result captured, timeout stays 0.
  - Capture coincident with drain of the previous result -> res_valid stays 1 with the new value.
- Reset mid-RUN:
  - Stimulus: assert rst 2 cycles into RUN.
  - Required: all outputs at reset values the next cycle; no res_valid; a new token launches cleanly afterwards.
